// File: rtl/bexkat1_intunit.sv
// Multi-cycle integer unit for the bexkat1 execute stage: iterative shift-add
// multiply, restoring divide and single-pass unary ops behind start/done.
module bexkat1_intunit #(
   parameter int WIDTH  = 32,
   parameter int FUNC_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [FUNC_W-1:0] func_i,
   input  logic [WIDTH-1:0]  a_i,
   input  logic [WIDTH-1:0]  b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [WIDTH-1:0]  result_o,
   output logic              divzero_o,
   output logic              illegal_o
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [FUNC_W-1:0] F_MUL   = FUNC_W'(0);
   localparam logic [FUNC_W-1:0] F_DIV   = FUNC_W'(1);
   localparam logic [FUNC_W-1:0] F_MOD   = FUNC_W'(2);
   localparam logic [FUNC_W-1:0] F_MULU  = FUNC_W'(3);
   localparam logic [FUNC_W-1:0] F_DIVU  = FUNC_W'(4);
   localparam logic [FUNC_W-1:0] F_MODU  = FUNC_W'(5);
   localparam logic [FUNC_W-1:0] F_MULX  = FUNC_W'(6);
   localparam logic [FUNC_W-1:0] F_MULUX = FUNC_W'(7);
   localparam logic [FUNC_W-1:0] F_EXT   = FUNC_W'(8);
   localparam logic [FUNC_W-1:0] F_EXTB  = FUNC_W'(9);
   localparam logic [FUNC_W-1:0] F_COM   = FUNC_W'(10);
   localparam logic [FUNC_W-1:0] F_NEG   = FUNC_W'(11);

   // PREP registers operand magnitudes so the negate is off the iteration path.
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_DIV, S_FIX} state_t;

   state_t               state_q;
   logic [FUNC_W-1:0]    func_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic                 negRes_q, negRem_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   prod_q, mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [WIDTH-1:0]     rem_q, quo_q, divisor_q;
   logic                 busy_q, done_q, divzero_q, illegal_q;
   logic [WIDTH-1:0]     result_q;

   logic                 isMul, isDiv, isSigned, isHigh, isMod, isIllegal, bZero;
   logic [WIDTH-1:0]     magA, magB;
   logic [WIDTH:0]       divShift, divDiff;
   logic [WIDTH-1:0]     rem_d, quo_d;
   logic [2*WIDTH-1:0]   prod_d;
   logic [2*WIDTH-1:0]   prodFix;
   logic [WIDTH-1:0]     quoFix, remFix, fixResult;

   always_comb begin
      isMul     = (func_q == F_MUL) || (func_q == F_MULU) ||
                  (func_q == F_MULX) || (func_q == F_MULUX);
      isDiv     = (func_q == F_DIV) || (func_q == F_MOD) ||
                  (func_q == F_DIVU) || (func_q == F_MODU);
      isSigned  = (func_q == F_MUL) || (func_q == F_DIV) ||
                  (func_q == F_MOD) || (func_q == F_MULX);
      isHigh    = (func_q == F_MULX) || (func_q == F_MULUX);
      isMod     = (func_q == F_MOD) || (func_q == F_MODU);
      isIllegal = (func_q > F_NEG);
      bZero     = (b_q == '0);
      magA      = (isSigned && a_q[WIDTH-1]) ? -a_q : a_q;
      magB      = (isSigned && b_q[WIDTH-1]) ? -b_q : b_q;
   end

   // One restoring-divide step and one shift-add multiply step per cycle.
   always_comb begin
      divShift = {rem_q, quo_q[WIDTH-1]};
      divDiff  = divShift - {1'b0, divisor_q};
      rem_d    = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
      quo_d    = {quo_q[WIDTH-2:0], ~divDiff[WIDTH]};
      prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
   end

   always_comb begin
      prodFix   = negRes_q ? -prod_q : prod_q;
      quoFix    = negRes_q ? -quo_q : quo_q;
      remFix    = negRem_q ? -rem_q : rem_q;
      fixResult = '0;
      if (isIllegal) begin
         fixResult = '0;
      end else if (isMul) begin
         fixResult = isHigh ? prodFix[2*WIDTH-1:WIDTH] : prodFix[WIDTH-1:0];
      end else if (isDiv) begin
         if (bZero) fixResult = isMod ? a_q : '1;
         else       fixResult = isMod ? remFix : quoFix;
      end else begin
         case (func_q)
            F_EXT:   fixResult = WIDTH'($signed(a_q[15:0]));
            F_EXTB:  fixResult = WIDTH'($signed(a_q[7:0]));
            F_COM:   fixResult = ~a_q;
            F_NEG:   fixResult = -a_q;
            default: fixResult = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         func_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         cnt_q     <= '0;
         prod_q    <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         illegal_q <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  func_q  <= func_i;
                  a_q     <= a_i;
                  b_q     <= b_i;
                  busy_q  <= 1'b1;
                  state_q <= S_PREP;
               end
            end
            S_PREP: begin
               negRes_q <= isSigned & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               negRem_q <= isSigned & a_q[WIDTH-1];
               cnt_q    <= CW'(WIDTH - 1);
               if (isIllegal) begin
                  state_q <= S_FIX;
               end else if (isMul) begin
                  prod_q   <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, magA};
                  mplier_q <= magB;
                  state_q  <= S_MUL;
               end else if (isDiv && !bZero) begin
                  rem_q     <= '0;
                  quo_q     <= magA;
                  divisor_q <= magB;
                  state_q   <= S_DIV;
               end else begin
                  state_q <= S_FIX;
               end
            end
            S_MUL: begin
               prod_q   <= prod_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= S_FIX;
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= S_FIX;
            end
            S_FIX: begin
               result_q  <= fixResult;
               divzero_q <= isDiv & bZero & ~isIllegal;
               illegal_q <= isIllegal;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign result_o  = result_q;
   assign divzero_o = divzero_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_bexkat1_intunit.sv
// Scoreboard bench for bexkat1_intunit at WIDTH=32: directed vectors push
// expected results; a monitor pops and compares on every done_o pulse.
module tb_bexkat1_intunit;

   localparam int W = 32;

   // Driving ports
   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic [3:0]    func_i = '0;
   logic [W-1:0]  a_i = '0;
   logic [W-1:0]  b_i = '0;
   logic          busy_o, done_o, divzero_o, illegal_o;
   logic [W-1:0]  result_o;

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic         dz;
      logic         ill;
      int           doneCyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   nCompared = 0;
   int   nFailed = 0;

   bexkat1_intunit #(.WIDTH(W), .FUNC_W(4)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (start_i),
      .func_i    (func_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .divzero_o (divzero_o),
      .illegal_o (illegal_o)
   );

   // Free-running clock plus an edge counter used for latency checks
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input string what,
                              input logic [63:0] actual, input logic [63:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nFailed++;
         $display("[TB] FAIL %s.%s actual=0x%0h required=0x%0h", name, what, actual, expected);
      end
   endtask

   // Monitor: every done_o pulse must match the oldest outstanding expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (done_o) begin
            if (sb.size() == 0) begin
               nCompared++;
               nFailed++;
               $display("[TB] FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               checkOutput(e.name, "result", 64'(result_o), 64'(e.res));
               checkOutput(e.name, "divzero", 64'(divzero_o), 64'(e.dz));
               checkOutput(e.name, "illegal", 64'(illegal_o), 64'(e.ill));
               checkOutput(e.name, "doneCycle", 64'(cyc), 64'(e.doneCyc));
               checkOutput(e.name, "busyAtDone", 64'(busy_o), 64'd0);
            end
         end
      end
   end

   // Issue one start pulse and record what the DUT must return and when
   task automatic applyStimulus(input string name, input logic [3:0] fn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic dz,
                                input logic ill, input int lat);
      exp_t e;
      @(negedge clk_i);
      func_i  = fn;
      a_i     = a;
      b_i     = b;
      start_i = 1'b1;
      e.name    = name;
      e.res     = res;
      e.dz      = dz;
      e.ill     = ill;
      e.doneCyc = cyc + 1 + lat;
      sb.push_back(e);
      @(negedge clk_i);
      start_i = 1'b0;
      a_i     = ~a;
      b_i     = ~b;
   endtask

   task automatic waitDone(input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(posedge clk_i);
         k++;
      end
      @(negedge clk_i);
      if (sb.size() != 0) begin
         nCompared++;
         nFailed++;
         $display("[TB] FAIL timeout outstanding=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk_i);
      checkOutput("reset", "busy", 64'(busy_o), 64'd0);
      checkOutput("reset", "done", 64'(done_o), 64'd0);
      checkOutput("reset", "result", 64'(result_o), 64'd0);
      checkOutput("reset", "divzero", 64'(divzero_o), 64'd0);
      checkOutput("reset", "illegal", 64'(illegal_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Multiply family
      applyStimulus("mul_7_m3", 4'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 34);
      checkOutput("mul_7_m3", "busyAfterAccept", 64'(busy_o), 64'd1);
      waitDone(60);
      applyStimulus("mulx", 4'd6, 32'h80000000, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
      waitDone(60);
      applyStimulus("mulux", 4'd7, 32'h80000000, 32'd2, 32'h00000001, 1'b0, 1'b0, 34);
      waitDone(60);
      applyStimulus("mulu_max", 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 34);
      waitDone(60);

      // Divide family including the MIN / -1 corner
      applyStimulus("div_m7_2", 4'd1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, 34);
      waitDone(60);
      applyStimulus("mod_m7_2", 4'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 34);
      waitDone(60);
      applyStimulus("div_min_m1", 4'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 34);
      waitDone(60);
      applyStimulus("mod_min_m1", 4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 34);
      waitDone(60);

      // Divide by zero, then a multiply that must clear the flag
      applyStimulus("divu_by0", 4'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 2);
      waitDone(20);
      applyStimulus("modu_by0", 4'd5, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, 2);
      waitDone(20);
      applyStimulus("mul_3_4", 4'd0, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, 34);
      waitDone(60);

      // Unary ops and an illegal code
      applyStimulus("extb", 4'd9, 32'h000000F0, 32'd0, 32'hFFFFFFF0, 1'b0, 1'b0, 2);
      waitDone(20);
      applyStimulus("ext", 4'd8, 32'h00007FFF, 32'd0, 32'h00007FFF, 1'b0, 1'b0, 2);
      waitDone(20);
      applyStimulus("com", 4'd10, 32'h0F0F1234, 32'd0, 32'hF0F0EDCB, 1'b0, 1'b0, 2);
      waitDone(20);
      applyStimulus("neg_1", 4'd11, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 2);
      waitDone(20);
      applyStimulus("neg_min", 4'd11, 32'h80000000, 32'd0, 32'h80000000, 1'b0, 1'b0, 2);
      waitDone(20);
      applyStimulus("illegal13", 4'd13, 32'h12345678, 32'd9, 32'd0, 1'b0, 1'b1, 2);
      waitDone(20);

      // A start while busy must be ignored
      applyStimulus("divu_100_7", 4'd4, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 34);
      repeat (3) @(negedge clk_i);
      func_i  = 4'd0;
      a_i     = 32'd3;
      b_i     = 32'd4;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      waitDone(60);

      // Reset in the middle of a divide aborts it with no done pulse
      @(negedge clk_i);
      func_i  = 4'd1;
      a_i     = 32'd1000;
      b_i     = 32'd3;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (8) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      checkOutput("midReset", "busy", 64'(busy_o), 64'd0);
      checkOutput("midReset", "done", 64'(done_o), 64'd0);
      checkOutput("midReset", "result", 64'(result_o), 64'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (40) @(negedge clk_i);
      checkOutput("afterReset", "busy", 64'(busy_o), 64'd0);

      applyStimulus("div_100_m7", 4'd1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1'b0, 34);
      waitDone(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
